// File: rtl/period_meas_pkg.sv
// Shared types and sizing for the crossing-period measurement controller.
package period_meas_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        MEASURE = 3'd2,
        DONE    = 3'd3,
        ERR     = 3'd4
    } meas_state_t;

    localparam int W_N_MAX_DEF    = 16;
    localparam int N_LOG2_MAX_DEF = 3;
    localparam int ACC_W          = W_N_MAX_DEF + N_LOG2_MAX_DEF;

    // Accumulator holds 2**n_log2_max counts without overflow.
    function automatic int acc_width(input int w_n, input int n_log2_max);
        return w_n + n_log2_max;
    endfunction

endpackage

// File: rtl/period_meas_ctrl_if.sv
// Control-register and period-counter signals of period_meas_ctrl.
// Optional min/max outputs exist only when PERIOD_MEAS_MINMAX_EN is defined.
interface period_meas_ctrl_if #(
    parameter int W_N_MAX    = 16,
    parameter int N_LOG2_MAX = 3
);
    localparam int W_NL = $clog2(N_LOG2_MAX + 1);

    logic               start;
    logic               abort;
    logic [W_NL-1:0]    n_log2;
    logic               meas_valid;
    logic [W_N_MAX-1:0] meas_count;
    logic               meas_en;
    logic               meas_rst;
    logic               busy;
    logic [W_N_MAX-1:0] result;
    logic               result_valid;
    logic               timeout_err;
`ifdef PERIOD_MEAS_MINMAX_EN
    logic [W_N_MAX-1:0] result_min;
    logic [W_N_MAX-1:0] result_max;
`endif

    modport master (
        input  start, abort, n_log2, meas_valid, meas_count,
        output meas_en, meas_rst, busy, result, result_valid, timeout_err
`ifdef PERIOD_MEAS_MINMAX_EN
        , output result_min, result_max
`endif
    );

    modport slave (
        output start, abort, n_log2, meas_valid, meas_count,
        input  meas_en, meas_rst, busy, result, result_valid, timeout_err
`ifdef PERIOD_MEAS_MINMAX_EN
        , input result_min, result_max
`endif
    );

endinterface

// File: rtl/meas_timeout_cnt.sv
// Gap timer between valid edges; expired holds once TIMEOUT-1 is reached.
module meas_timeout_cnt #(
    parameter int TIMEOUT = 65535,
    parameter int W_TO    = 16
) (
    input  logic clk,
    input  logic reset_l,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    logic [W_TO-1:0] cnt_q;

    assign expired_o = (cnt_q == W_TO'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && !expired_o) begin
            cnt_q <= cnt_q + W_TO'(1);
        end
    end

endmodule

// File: rtl/period_meas_ctrl.sv
// Sequences one period counter: arm, average 2**n_log2 counts, flag gap timeout.
// PERIOD_MEAS_MINMAX_EN adds result_min/result_max publication.
//   state   | meaning
//   IDLE    | waiting for start
//   ARM     | one-cycle counter clear
//   MEASURE | counter enabled, accumulating on valid rising edges
//   DONE    | publish averaged result
//   ERR     | gap timeout, raise sticky error
module period_meas_ctrl
    import period_meas_pkg::*;
#(
    parameter int W_N_MAX    = 16,
    parameter int N_LOG2_MAX = 3,
    parameter int TIMEOUT    = 65535,
    parameter int W_TO       = 16
) (
    input  logic              clk,
    input  logic              reset_l,
    period_meas_ctrl_if.master pm
);

    localparam int ACC_WIDTH = acc_width(W_N_MAX, N_LOG2_MAX);
    localparam int W_NL      = $clog2(N_LOG2_MAX + 1);
    localparam int W_IDX     = N_LOG2_MAX + 1;

    meas_state_t          state_q, state_d;
    logic [W_NL-1:0]      n_q, n_clamp;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [W_IDX-1:0]     idx_q, idx_last;
    logic                 valid_q;
    logic [W_N_MAX-1:0]   result_q;
    logic                 result_valid_q;
    logic                 err_q;
    logic                 rise, start_ok, rise_m, to_expired;

    assign rise     = pm.meas_valid & ~valid_q;
    assign start_ok = (state_q == IDLE) && pm.start && !pm.abort;
    assign rise_m   = (state_q == MEASURE) && rise;
    assign idx_last = (W_IDX'(1) << n_q) - W_IDX'(1);

    generate
        if ((1 << W_NL) - 1 > N_LOG2_MAX) begin : g_clamp
            assign n_clamp = (pm.n_log2 > W_NL'(N_LOG2_MAX)) ? W_NL'(N_LOG2_MAX) : pm.n_log2;
        end else begin : g_noclamp
            assign n_clamp = pm.n_log2;
        end
    endgenerate

    meas_timeout_cnt #(.TIMEOUT(TIMEOUT), .W_TO(W_TO)) u_to (
        .clk       (clk),
        .reset_l   (reset_l),
        .clr_i     (start_ok || rise_m),
        .inc_i     ((state_q == MEASURE) && !rise),
        .expired_o (to_expired)
    );

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (pm.abort && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_ok) state_d = ARM;
                ARM:     state_d = MEASURE;
                MEASURE: begin
                    // A rise always wins over an expiring timer.
                    if (rise) begin
                        if (idx_q == idx_last) state_d = DONE;
                    end else if (to_expired) begin
                        state_d = ERR;
                    end
                end
                DONE:    state_d = IDLE;
                ERR:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pm.meas_en  = (state_q == MEASURE);
        pm.meas_rst = (state_q == ARM);
        pm.busy     = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            valid_q        <= 1'b0;
            n_q            <= '0;
            acc_q          <= '0;
            idx_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            valid_q        <= pm.meas_valid;
            result_valid_q <= 1'b0;
            if (start_ok) begin
                n_q   <= n_clamp;
                acc_q <= '0;
                idx_q <= '0;
                err_q <= 1'b0;
            end
            if (rise_m) begin
                acc_q <= acc_q + ACC_WIDTH'(pm.meas_count);
                idx_q <= idx_q + W_IDX'(1);
            end
            if (state_q == DONE && !pm.abort) begin
                result_q       <= W_N_MAX'(acc_q >> n_q);
                result_valid_q <= 1'b1;
            end
            if (state_q == ERR && !pm.abort) err_q <= 1'b1;
        end
    end

    assign pm.result       = result_q;
    assign pm.result_valid = result_valid_q;
    assign pm.timeout_err  = err_q;

`ifdef PERIOD_MEAS_MINMAX_EN
    logic [W_N_MAX-1:0] min_q, max_q, rmin_q, rmax_q;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            min_q  <= '0;
            max_q  <= '0;
            rmin_q <= '0;
            rmax_q <= '0;
        end else begin
            if (rise_m) begin
                if (idx_q == '0 || pm.meas_count < min_q) min_q <= pm.meas_count;
                if (idx_q == '0 || pm.meas_count > max_q) max_q <= pm.meas_count;
            end
            if (state_q == DONE && !pm.abort) begin
                rmin_q <= min_q;
                rmax_q <= max_q;
            end
        end
    end

    assign pm.result_min = rmin_q;
    assign pm.result_max = rmax_q;
`endif

endmodule

// File: tb/tb_period_meas_ctrl.sv
// Scoreboard bench for period_meas_ctrl; expected results queued at stimulus, popped on result_valid.
module tb_period_meas_ctrl;

    localparam int WN = 16;
    localparam int NL = 3;
    localparam int TO = 20;

    typedef struct {
        logic [WN-1:0] res;
        logic [WN-1:0] mn;
        logic [WN-1:0] mx;
        string         name;
    } exp_t;

    logic clk = 1'b0;
    logic reset_l = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    period_meas_ctrl_if #(.W_N_MAX(WN), .N_LOG2_MAX(NL)) dif ();

    period_meas_ctrl #(
        .W_N_MAX(WN), .N_LOG2_MAX(NL), .TIMEOUT(TO), .W_TO(16)
    ) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .pm      (dif.master)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input int res, input int mn, input int mx);
        exp_t e;
        e.res = WN'(res); e.mn = WN'(mn); e.mx = WN'(mx); e.name = name;
        sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (dif.result_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pulse: got result_valid with result %0d, required no pulse", dif.result);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_result"}, 32'(dif.result), 32'(e.res));
`ifdef PERIOD_MEAS_MINMAX_EN
                    check({e.name, "_min"}, 32'(dif.result_min), 32'(e.mn));
                    check({e.name, "_max"}, 32'(dif.result_max), 32'(e.mx));
`endif
                end
            end
        end
    endtask

    task automatic do_start(input int n);
        dif.start  = 1'b1;
        dif.n_log2 = 2'(n);
        tick();
        dif.start  = 1'b0;
    endtask

    task automatic send(input int cnt, input int gap);
        dif.meas_valid = 1'b1;
        dif.meas_count = WN'(cnt);
        tick();
        dif.meas_valid = 1'b0;
        for (int i = 0; i < gap; i++) tick();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check({name, "_drain"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        dif.start = 1'b0; dif.abort = 1'b0; dif.n_log2 = '0;
        dif.meas_valid = 1'b0; dif.meas_count = '0;
        fork monitor(); join_none
        #23 reset_l = 1'b1;
        tick();
        check("rst_busy", 32'(dif.busy), 0);
        check("rst_meas_en", 32'(dif.meas_en), 0);
        check("rst_meas_rst", 32'(dif.meas_rst), 0);
        check("rst_result", 32'(dif.result), 0);
        check("rst_result_valid", 32'(dif.result_valid), 0);
        check("rst_timeout_err", 32'(dif.timeout_err), 0);

        // Four periods averaged, exact latency at the last rise.
        push("avg4", 100, 98, 102);
        do_start(2);
        check("arm_meas_rst", 32'(dif.meas_rst), 1);
        check("arm_meas_en", 32'(dif.meas_en), 0);
        tick();
        check("meas_meas_rst", 32'(dif.meas_rst), 0);
        check("meas_meas_en", 32'(dif.meas_en), 1);
        send(100, 1); send(102, 1); send(98, 1); send(100, 0);
        check("avg4_no_early_pulse", 32'(dif.result_valid), 0);
        tick();
        check("avg4_pulse", 32'(dif.result_valid), 1);
        check("avg4_busy_low", 32'(dif.busy), 0);
        drain("avg4");

        // Single period, valid held for 5 cycles.
        push("hold1", 37, 37, 37);
        do_start(0); tick();
        dif.meas_valid = 1'b1; dif.meas_count = 16'd37;
        for (int i = 0; i < 5; i++) tick();
        dif.meas_valid = 1'b0;
        drain("hold1");

        // Held level counts once: two periods 37 (held) and 41.
        push("hold2", 39, 37, 41);
        do_start(1); tick();
        dif.meas_valid = 1'b1; dif.meas_count = 16'd37;
        for (int i = 0; i < 5; i++) tick();
        dif.meas_valid = 1'b0; tick();
        send(41, 1);
        drain("hold2");

        // No valid edges: error exactly TIMEOUT+2 edges after start.
        do_start(1);
        for (int i = 0; i < TO + 1; i++) tick();
        check("to_err_not_yet", 32'(dif.timeout_err), 0);
        check("to_busy_in_err", 32'(dif.busy), 1);
        check("to_meas_en_err", 32'(dif.meas_en), 0);
        tick();
        check("to_err_set", 32'(dif.timeout_err), 1);
        check("to_busy_low", 32'(dif.busy), 0);
        check("to_result_kept", 32'(dif.result), 39);
        for (int i = 0; i < 3; i++) tick();
        check("to_err_sticky", 32'(dif.timeout_err), 1);

        // Abort after two of four rises.
        do_start(2);
        check("start_clears_err", 32'(dif.timeout_err), 0);
        tick();
        send(200, 1); send(200, 1);
        dif.abort = 1'b1; tick(); dif.abort = 1'b0;
        check("abort_busy", 32'(dif.busy), 0);
        check("abort_meas_en", 32'(dif.meas_en), 0);
        check("abort_no_err", 32'(dif.timeout_err), 0);
        tick(); tick();

        // Fresh run after abort; a start mid-measurement must be ignored.
        push("after_abort", 50, 50, 50);
        do_start(2); tick();
        send(50, 1); send(50, 1);
        do_start(0);
        check("start_busy_ignored", 32'(dif.busy), 1);
        send(50, 1); send(50, 1);
        drain("after_abort");

        // Min/max spread.
        push("spread", 100, 90, 110);
        do_start(2); tick();
        send(90, 1); send(110, 1); send(100, 1); send(100, 1);
        drain("spread");

        // Async reset mid-measurement.
        do_start(2); tick();
        send(60, 1);
        check("pre_rst_meas_en", 32'(dif.meas_en), 1);
        #2 reset_l = 1'b0;
        #1;
        check("arst_meas_en", 32'(dif.meas_en), 0);
        check("arst_busy", 32'(dif.busy), 0);
        check("arst_meas_rst", 32'(dif.meas_rst), 0);
        check("arst_result", 32'(dif.result), 0);
        check("arst_timeout_err", 32'(dif.timeout_err), 0);
        #3 reset_l = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("post_rst_result_valid", 32'(dif.result_valid), 0);
        drain("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
